// File: rtl/uvmt_apb_st_bridge_pkg.sv
// Shared types and constants for the APB self-test bridge.
package uvmt_apb_st_bridge_pkg;

  localparam int unsigned APB_PROT_WIDTH = 3;
  localparam int unsigned ADDR_W_MAX     = 32;
  localparam int unsigned DATA_W_MAX     = 32;
  localparam int unsigned STRB_W_MAX     = DATA_W_MAX / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  // Upstream request captured in IDLE and replayed on the downstream bus.
  typedef struct packed {
    logic [ADDR_W_MAX-1:0]     addr;
    logic                      write;
    logic [DATA_W_MAX-1:0]     wdata;
    logic [STRB_W_MAX-1:0]     strb;
    logic [APB_PROT_WIDTH-1:0] prot;
  } req_t;

endpackage

// File: rtl/uvmt_apb_st_bridge_tmr.sv
// Saturating wait-state counter; expire_c flags the last allowed ACCESS cycle.
module uvmt_apb_st_bridge_tmr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_W'(CNT_MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A zero TIMEOUT_CYCLES disables expiry entirely.
  assign expire_c = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(CNT_LAST));

endmodule

// File: rtl/uvmt_apb_st_bridge.sv
// Registered APB-to-APB bridge: terminates the upstream transfer, replays it
// downstream, and returns the response one cycle after downstream completion.
module uvmt_apb_st_bridge
  import uvmt_apb_st_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     m_paddr,
  input  logic                      m_psel,
  input  logic                      m_penable,
  input  logic                      m_pwrite,
  input  logic [DATA_WIDTH-1:0]     m_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   m_pstrb,
  input  logic [APB_PROT_WIDTH-1:0] m_pprot,
  output logic [DATA_WIDTH-1:0]     m_prdata,
  output logic                      m_pready,
  output logic                      m_pslverr,
  output logic [ADDR_WIDTH-1:0]     s_paddr,
  output logic                      s_psel,
  output logic                      s_penable,
  output logic                      s_pwrite,
  output logic [DATA_WIDTH-1:0]     s_pwdata,
  output logic [DATA_WIDTH/8-1:0]   s_pstrb,
  output logic [APB_PROT_WIDTH-1:0] s_pprot,
  input  logic [DATA_WIDTH-1:0]     s_prdata,
  input  logic                      s_pready,
  input  logic                      s_pslverr,
  output logic                      busy,
  output logic                      timeout_pulse,
  output logic                      proto_err_pulse
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_t state;
  req_t   req;
  logic   aborted;
  logic   capture_c;
  logic   tmr_inc_c;
  logic   tmr_expire_c;

  assign capture_c = (state == IDLE) && m_psel && !m_penable;
  assign tmr_inc_c = (state == ACCESS) && !s_pready;

  uvmt_apb_st_bridge_tmr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (capture_c),
    .inc      (tmr_inc_c),
    .expire_c (tmr_expire_c)
  );

  // Downstream request fields come straight from the capture register.
  assign s_paddr  = req.addr[ADDR_WIDTH-1:0];
  assign s_pwrite = req.write;
  assign s_pwdata = req.wdata[DATA_WIDTH-1:0];
  assign s_pstrb  = req.strb[STRB_WIDTH-1:0];
  assign s_pprot  = req.prot;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      req             <= '0;
      aborted         <= 1'b0;
      s_psel          <= 1'b0;
      s_penable       <= 1'b0;
      m_prdata        <= '0;
      m_pready        <= 1'b0;
      m_pslverr       <= 1'b0;
      busy            <= 1'b0;
      timeout_pulse   <= 1'b0;
      proto_err_pulse <= 1'b0;
    end else begin
      timeout_pulse   <= 1'b0;
      proto_err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_c) begin
            req <= '{addr:  ADDR_W_MAX'(m_paddr),
                     write: m_pwrite,
                     wdata: DATA_W_MAX'(m_pwdata),
                     strb:  STRB_W_MAX'(m_pstrb),
                     prot:  m_pprot};
            aborted <= 1'b0;
            s_psel  <= 1'b1;
            busy    <= 1'b1;
            state   <= SETUP;
          end else if (m_psel && m_penable) begin
            // Access phase with no preceding setup: answer with an error.
            m_pready        <= 1'b1;
            m_pslverr       <= 1'b1;
            m_prdata        <= '0;
            proto_err_pulse <= 1'b1;
            busy            <= 1'b1;
            state           <= RESP;
          end
        end
        SETUP: begin
          s_penable <= 1'b1;
          state     <= ACCESS;
          if (!m_psel && !aborted) begin
            aborted         <= 1'b1;
            proto_err_pulse <= 1'b1;
          end
        end
        ACCESS: begin
          if (!m_psel && !aborted) begin
            aborted         <= 1'b1;
            proto_err_pulse <= 1'b1;
          end
          if (s_pready || tmr_expire_c) begin
            s_psel        <= 1'b0;
            s_penable     <= 1'b0;
            timeout_pulse <= !s_pready;
            // A master that walked away gets no response.
            if (aborted || !m_psel) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              m_pready  <= 1'b1;
              m_prdata  <= (s_pready && !req.write) ? s_prdata : '0;
              m_pslverr <= s_pready ? s_pslverr : 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          m_pready  <= 1'b0;
          m_prdata  <= '0;
          m_pslverr <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uvmt_apb_st_bridge.sv
// Directed bench for uvmt_apb_st_bridge with a response scoreboard.
module tb_uvmt_apb_st_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m_paddr;
  logic          m_psel;
  logic          m_penable;
  logic          m_pwrite;
  logic [DW-1:0] m_pwdata;
  logic [3:0]    m_pstrb;
  logic [2:0]    m_pprot;
  logic [DW-1:0] m_prdata;
  logic          m_pready;
  logic          m_pslverr;
  logic [AW-1:0] s_paddr;
  logic          s_psel;
  logic          s_penable;
  logic          s_pwrite;
  logic [DW-1:0] s_pwdata;
  logic [3:0]    s_pstrb;
  logic [2:0]    s_pprot;
  logic [DW-1:0] s_prdata;
  logic          s_pready;
  logic          s_pslverr;
  logic          busy;
  logic          timeout_pulse;
  logic          proto_err_pulse;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uvmt_apb_st_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pprot(m_pprot), .m_prdata(m_prdata), .m_pready(m_pready),
    .m_pslverr(m_pslverr), .s_paddr(s_paddr), .s_psel(s_psel),
    .s_penable(s_penable), .s_pwrite(s_pwrite), .s_pwdata(s_pwdata),
    .s_pstrb(s_pstrb), .s_pprot(s_pprot), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .busy(busy),
    .timeout_pulse(timeout_pulse), .proto_err_pulse(proto_err_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Full upstream transfer; the downstream slave inserts 'waits' wait states
  // (waits >= TO means the slave never answers).
  task automatic xfer(input logic [AW-1:0] addr, input logic wr,
                      input logic [DW-1:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input int waits,
                      input logic [DW-1:0] rdata, input logic serr);
    exp_t e;
    exp_t got;
    int   cyc;
    int   acc;
    int   idle_busy;
    int   exp_cyc;
    int   exp_acc;
    bit   stuck;
    stuck       = (waits >= int'(TO));
    exp_cyc     = stuck ? 2 + int'(TO) : 3 + waits;
    exp_acc     = stuck ? int'(TO) : waits + 1;
    e.rdata     = (stuck || wr) ? '0 : rdata;
    e.err       = stuck ? 1'b1 : serr;
    e.to        = stuck;
    sb.push_back(e);

    m_paddr   = addr;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    m_pwrite  = wr;
    m_pwdata  = wdata;
    m_pstrb   = strb;
    m_pprot   = prot;
    s_prdata  = wr ? 32'hAAAA_5555 : rdata;
    s_pslverr = serr;
    s_pready  = 1'b0;
    tick();
    check("setup_s_psel", 64'(s_psel), 64'd1);
    check("setup_s_penable", 64'(s_penable), 64'd0);
    check("setup_s_paddr", 64'(s_paddr), 64'(addr));
    check("setup_s_pwrite", 64'(s_pwrite), 64'(wr));
    check("setup_s_pstrb", 64'(s_pstrb), 64'(strb));
    check("setup_s_pprot", 64'(s_pprot), 64'(prot));
    check("setup_busy", 64'(busy), 64'd1);
    m_penable = 1'b1;
    m_pwdata  = ~wdata;
    tick();
    check("access_s_pwdata", 64'(s_pwdata), 64'(wdata));

    cyc       = 2;
    acc       = 0;
    idle_busy = 0;
    while (m_pready !== 1'b1 && cyc < 40) begin
      if (s_penable === 1'b1) acc++;
      if (busy !== 1'b1) idle_busy++;
      check("wait_m_pready_low", 64'(m_pready), 64'd0);
      s_pready = (cyc - 2 >= waits);
      tick();
      cyc++;
    end
    check("resp_m_pready", 64'(m_pready), 64'd1);
    check("resp_cycle", 64'(cyc), 64'(exp_cyc));
    check("access_cycles", 64'(acc), 64'(exp_acc));
    check("busy_during_xfer", 64'(idle_busy), 64'd0);
    check("resp_s_psel", 64'(s_psel), 64'd0);
    check("resp_busy", 64'(busy), 64'd1);
    check("sb_pending", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("resp_m_prdata", 64'(m_prdata), 64'(got.rdata));
      check("resp_m_pslverr", 64'(m_pslverr), 64'(got.err));
      check("resp_timeout_pulse", 64'(timeout_pulse), 64'(got.to));
    end

    m_psel    = 1'b0;
    m_penable = 1'b0;
    s_pready  = 1'b0;
    tick();
    check("post_m_pready", 64'(m_pready), 64'd0);
    check("post_m_pslverr", 64'(m_pslverr), 64'd0);
    check("post_m_prdata", 64'(m_prdata), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
    check("post_timeout_pulse", 64'(timeout_pulse), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_pready"}, 64'(m_pready), 64'd0);
    check({tag, "_m_pslverr"}, 64'(m_pslverr), 64'd0);
    check({tag, "_m_prdata"}, 64'(m_prdata), 64'd0);
    check({tag, "_s_psel"}, 64'(s_psel), 64'd0);
    check({tag, "_s_penable"}, 64'(s_penable), 64'd0);
    check({tag, "_s_paddr"}, 64'(s_paddr), 64'd0);
    check({tag, "_s_pwdata"}, 64'(s_pwdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_timeout_pulse"}, 64'(timeout_pulse), 64'd0);
    check({tag, "_proto_err_pulse"}, 64'(proto_err_pulse), 64'd0);
  endtask

  initial begin
    int n_ready;
    int n_proto;
    exp_t e;
    exp_t got;
    reset_n   = 1'b0;
    m_paddr   = '0;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    m_pwrite  = 1'b0;
    m_pwdata  = '0;
    m_pstrb   = '0;
    m_pprot   = '0;
    s_prdata  = '0;
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, '0, 1'b0);
    xfer(32'h44, 1'b0, 32'h0, 4'h0, 3'b001, 3, 32'h1234_5678, 1'b0);
    xfer(32'h80, 1'b0, 32'h0, 4'h0, 3'b000, 100, 32'hCAFE_F00D, 1'b0);
    xfer(32'h20, 1'b1, 32'h0BAD_F00D, 4'h3, 3'b100, 0, '0, 1'b1);
    xfer(32'h24, 1'b0, 32'h0, 4'h0, 3'b000, 2, 32'h5A5A_A5A5, 1'b1);

    // Reset while the downstream transfer sits in ACCESS.
    m_paddr   = 32'h30;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    m_pwrite  = 1'b1;
    m_pwdata  = 32'h1111_2222;
    m_pstrb   = 4'hF;
    s_pready  = 1'b0;
    tick();
    m_penable = 1'b1;
    tick();
    check("pre_reset_s_penable", 64'(s_penable), 64'd1);
    reset_n   = 1'b0;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    tick();
    check_all_zero("midreset");
    reset_n = 1'b1;
    tick();
    xfer(32'h34, 1'b0, 32'h0, 4'h0, 3'b000, 0, 32'h7777_8888, 1'b0);

    // Access phase seen in IDLE without a setup phase.
    e.rdata = '0;
    e.err   = 1'b1;
    e.to    = 1'b0;
    sb.push_back(e);
    m_psel    = 1'b1;
    m_penable = 1'b1;
    tick();
    check("noset_m_pready", 64'(m_pready), 64'd1);
    check("noset_proto_err_pulse", 64'(proto_err_pulse), 64'd1);
    check("sb_pending", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("noset_m_pslverr", 64'(m_pslverr), 64'(got.err));
      check("noset_m_prdata", 64'(m_prdata), 64'(got.rdata));
    end
    m_psel    = 1'b0;
    m_penable = 1'b0;
    tick();
    check("noset_post_m_pready", 64'(m_pready), 64'd0);
    check("noset_post_proto", 64'(proto_err_pulse), 64'd0);
    check("noset_post_m_pslverr", 64'(m_pslverr), 64'd0);

    // Master drops PSEL while the downstream transfer is still waiting.
    m_paddr   = 32'h50;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    m_pwrite  = 1'b0;
    s_pready  = 1'b0;
    tick();
    m_penable = 1'b1;
    tick();
    m_psel    = 1'b0;
    m_penable = 1'b0;
    tick();
    check("drop_s_psel_held", 64'(s_psel), 64'd1);
    n_ready = 0;
    n_proto = (proto_err_pulse === 1'b1) ? 1 : 0;
    s_pready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      s_pready = 1'b0;
      if (m_pready === 1'b1) n_ready++;
      if (proto_err_pulse === 1'b1) n_proto++;
    end
    check("drop_m_pready_count", 64'(n_ready), 64'd0);
    check("drop_proto_count", 64'(n_proto), 64'd1);
    check("drop_busy", 64'(busy), 64'd0);
    check("drop_s_psel", 64'(s_psel), 64'd0);

    xfer(32'h60, 1'b1, 32'h0F0F_0F0F, 4'h5, 3'b011, 1, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
